// File: rtl/msg_disasm.sv
// Message disassembler: pops one packet from the TX FIFO and streams it word 0 first
// over a valid/ready interface. Define MSG_DISASM_HEADER_EN to prefix each packet with HEADER_WORD.
module msg_disasm #(
  parameter int unsigned            WORD_SIZE        = 8,
  parameter int unsigned            WORDS_PER_PACKET = 4,
  parameter logic [WORD_SIZE-1:0]   HEADER_WORD      = 8'hA5
) (
  input  logic                                  clk,
  input  logic                                  n_reset,
  input  logic [WORD_SIZE*WORDS_PER_PACKET-1:0] fifo_data,
  input  logic                                  fifo_empty,
  output logic                                  fifo_rd_en,
  output logic [WORD_SIZE-1:0]                  data_out,
  output logic                                  data_out_valid,
  input  logic                                  data_out_ready,
  output logic                                  busy
);

  localparam int unsigned CW = $clog2(WORDS_PER_PACKET);
  localparam logic [CW-1:0] LAST = CW'(WORDS_PER_PACKET - 1);

  typedef logic [WORDS_PER_PACKET-1:0][WORD_SIZE-1:0] pkt_t;

  typedef enum logic [1:0] {
    SM_IDLE,
    SM_FETCH,
`ifdef MSG_DISASM_HEADER_EN
    SM_HDR,
`endif
    SM_TX
  } state_t;

  state_t          state;
  logic [CW-1:0]   ctr;
  logic [CW-1:0]   ctr_nxt;
  pkt_t            pkt;
  pkt_t            fifo_words;

  assign fifo_words = fifo_data;
  assign ctr_nxt    = ctr + CW'(1);
  assign busy       = (state != SM_IDLE);
  assign fifo_rd_en = n_reset && (state == SM_IDLE) && !fifo_empty;

  // data_out is registered one step ahead: loaded in FETCH with the first word on the wire,
  // then advanced on each handshake so it is stable for as long as ready stays low.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state          <= SM_IDLE;
      ctr            <= '0;
      pkt            <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      case (state)
        SM_IDLE: begin
          if (!fifo_empty) state <= SM_FETCH;
        end
        SM_FETCH: begin
          pkt            <= fifo_words;
          ctr            <= '0;
          data_out_valid <= 1'b1;
`ifdef MSG_DISASM_HEADER_EN
          data_out       <= HEADER_WORD;
          state          <= SM_HDR;
`else
          data_out       <= fifo_words[0];
          state          <= SM_TX;
`endif
        end
`ifdef MSG_DISASM_HEADER_EN
        SM_HDR: begin
          if (data_out_ready) begin
            data_out <= pkt[0];
            state    <= SM_TX;
          end
        end
`endif
        SM_TX: begin
          if (data_out_ready) begin
            if (ctr == LAST) begin
              data_out_valid <= 1'b0;
              state          <= SM_IDLE;
            end else begin
              ctr      <= ctr_nxt;
              data_out <= pkt[ctr_nxt];
            end
          end
        end
        default: state <= SM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_disasm.sv
// Directed self-checking bench for msg_disasm; follows MSG_DISASM_HEADER_EN when defined.
module tb_msg_disasm;

`ifdef MSG_DISASM_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic        clk = 1'b0;
  logic        n_reset;
  logic [31:0] fifo_data = '0;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  data_out;
  logic        data_out_valid;
  logic        data_out_ready;
  logic        busy;

  msg_disasm #(.WORD_SIZE(8), .WORDS_PER_PACKET(4), .HEADER_WORD(8'hA5)) dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .fifo_data      (fifo_data),
    .fifo_empty     (fifo_empty),
    .fifo_rd_en     (fifo_rd_en),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // FIFO model: data appears the cycle after the pop strobe
  logic [31:0] fifo_mem [16];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= fifo_mem[rd_ptr[3:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] wlog[$];
  int         wcyc[$];
  int         pop_cyc[$];
  int         idle_cyc = -1;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  logic       prev_busy  = 1'b0;

  always @(negedge clk) begin
    if (n_reset) begin
      if (fifo_rd_en) pop_cyc.push_back(cyc);
      if (prev_stall) begin
        check("stall_valid", 32'(data_out_valid), 32'd1);
        check("stall_data", 32'(data_out), 32'(prev_data));
      end
      if (data_out_valid && data_out_ready) begin
        wlog.push_back(data_out);
        wcyc.push_back(cyc);
      end
      if (prev_busy && !busy) idle_cyc = cyc;
    end
    prev_stall = n_reset && data_out_valid && !data_out_ready;
    prev_data  = data_out;
    prev_busy  = busy;
  end

  logic [7:0] exp_q[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] p);
    fifo_mem[wr_ptr[3:0]] = p;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic clear_logs;
    wlog.delete();
    wcyc.delete();
    pop_cyc.delete();
    exp_q.delete();
    idle_cyc = -1;
  endtask

  task automatic add_words(input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] w2, input logic [7:0] w3);
    if (HDR != 0) exp_q.push_back(8'hA5);
    exp_q.push_back(w0);
    exp_q.push_back(w1);
    exp_q.push_back(w2);
    exp_q.push_back(w3);
  endtask

  task automatic wait_words(input string tag, input int n, input int budget);
    int i;
    i = 0;
    while (wlog.size() < n && i < budget) begin
      tick();
      i++;
    end
    if (wlog.size() < n) check({tag, "_timeout"}, 32'(wlog.size()), 32'(n));
  endtask

  task automatic compare_words(input string tag);
    check({tag, "_count"}, 32'(wlog.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
      check($sformatf("%s_w%0d", tag, i), 32'(wlog[i]), 32'(exp_q[i]));
  endtask

  logic ready_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    n_reset        = 1'b0;
    data_out_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", 32'(data_out_valid), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);

    // idle with empty FIFO
    n_reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_rd_en", 32'(fifo_rd_en), 32'd0);
      check("idle_valid", 32'(data_out_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end

    // single packet, ready held high
    clear_logs();
    data_out_ready = 1'b1;
    push(32'hDEADBEEF);
    add_words(8'hEF, 8'hBE, 8'hAD, 8'hDE);
    wait_words("single", 4 + HDR, 40);
    repeat (6) tick();
    compare_words("single");
    check("single_pops", 32'(pop_cyc.size()), 32'd1);
    if (pop_cyc.size() == 1) begin
      for (int k = 0; k < wcyc.size(); k++)
        check($sformatf("single_lat%0d", k), 32'(wcyc[k] - pop_cyc[0]), 32'(2 + k));
      check("single_idle", 32'(idle_cyc - pop_cyc[0]), 32'(6 + HDR));
    end

    // back-pressure
    clear_logs();
    data_out_ready = ready_pat[0];
    push(32'h0F1E2D3C);
    add_words(8'h3C, 8'h2D, 8'h1E, 8'h0F);
    for (int i = 1; i < 40; i++) begin
      tick();
      data_out_ready = (i < 7) ? ready_pat[i] : 1'b1;
    end
    compare_words("bp");
    check("bp_pops", 32'(pop_cyc.size()), 32'd1);

    // three packets back to back
    clear_logs();
    data_out_ready = 1'b1;
    push(32'h11223344);
    push(32'h55667788);
    push(32'h99AABBCC);
    add_words(8'h44, 8'h33, 8'h22, 8'h11);
    add_words(8'h88, 8'h77, 8'h66, 8'h55);
    add_words(8'hCC, 8'hBB, 8'hAA, 8'h99);
    wait_words("b2b", 12 + 3 * HDR, 80);
    repeat (8) tick();
    compare_words("b2b");
    check("b2b_pops", 32'(pop_cyc.size()), 32'd3);
    if (pop_cyc.size() == 3) begin
      check("b2b_gap1", 32'(pop_cyc[1] - pop_cyc[0]), 32'(6 + HDR));
      check("b2b_gap2", 32'(pop_cyc[2] - pop_cyc[1]), 32'(6 + HDR));
    end

    // reset in the middle of a packet
    clear_logs();
    push(32'h11223344);
    push(32'h55667788);
    wait_words("mid", 2 + HDR, 40);
    n_reset = 1'b0;
    tick();
    check("midrst_valid", 32'(data_out_valid), 32'd0);
    check("midrst_data", 32'(data_out), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rd_en", 32'(fifo_rd_en), 32'd0);
    clear_logs();
    n_reset = 1'b1;
    add_words(8'h88, 8'h77, 8'h66, 8'h55);
    wait_words("postrst", 4 + HDR, 40);
    repeat (20) tick();
    compare_words("postrst");
    check("postrst_pops", 32'(pop_cyc.size()), 32'd1);
    check("postrst_empty", 32'(fifo_empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/msg_disasm.md
# msg_disasm

Message disassembler. Pops one WORDS_PER_PACKET-word packet from the transmit FIFO and serialises it, word 0 first, onto a WORD_SIZE-bit valid/ready stream feeding the UART transmitter. It sits between the TX FIFO read port and the UART TX, and is the return-path counterpart of the receive-side message assembler.

## Interface
- WORD_SIZE, 8, width of one stream word.
- WORDS_PER_PACKET, 4, words per packet; ≥2.
- HEADER_WORD, 8'hA5, sync word sent before each packet (only with MSG_DISASM_HEADER_EN).
- clk  in  1  clock.
- n_reset  in  1  reset; synchronous, active-low.
- fifo_data  in  WORD_SIZE*WORDS_PER_PACKET  FIFO read data; word i at bits [(i+1)*WORD_SIZE-1 : i*WORD_SIZE]; valid the cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO pop strobe.
- data_out  out  WORD_SIZE  word to UART TX.
- data_out_valid  out  1  data_out holds a word.
- data_out_ready  in  1  UART TX accepts a word.
- busy  out  1  high whenever state ≠ SM_IDLE.

## Operation
- States: SM_IDLE, SM_FETCH, SM_HDR (only with the macro), SM_TX.
- SM_IDLE: fifo_rd_en = !fifo_empty (combinational). If fifo_empty = 0 → SM_FETCH; otherwise stay.
- SM_FETCH: fifo_data is captured into the packet register and ctr is cleared to 0. Next state is SM_HDR with the macro, SM_TX without it.
- SM_HDR: data_out = HEADER_WORD, data_out_valid = 1. On data_out_valid && data_out_ready → SM_TX.
- SM_TX: data_out = word[ctr], data_out_valid = 1. On handshake: if ctr == WORDS_PER_PACKET-1 → SM_IDLE; otherwise ctr increments.
- ctr width is $clog2(WORDS_PER_PACKET). ctr never exceeds WORDS_PER_PACKET-1, and there is no wrap-around inside a packet.
- The packet register is written only in SM_FETCH, so FIFO activity during transmission has no effect.
- Valid/ready rules:
  - A transfer occurs on a rising edge with valid && ready.
  - Once data_out_valid is asserted, it and data_out stay stable until accepted.
  - data_out_ready is ignored while valid = 0.
- fifo_rd_en is never asserted outside SM_IDLE; exactly one pop per packet.
- Reset mid-operation: the current packet is discarded. Words already popped but not sent are lost, not replayed.

## Timing
- Reset values:
  - state = SM_IDLE, ctr = 0.
  - data_out_valid = 0, data_out = 0.
  - busy = 0.
  - fifo_rd_en = 0 while n_reset = 0.
- Latency: the first data_out_valid comes 2 cycles after the fifo_rd_en cycle.
- Words (ready held high): word k is accepted in cycle 2+k after the pop, +1 with the header.
- Packet period: with ready held high and the FIFO non-empty, a new fifo_rd_en occurs 1 cycle after the last word is accepted.
  - Period = WORDS_PER_PACKET+2 cycles, or +3 with the header.
- Back-pressure: each cycle of data_out_ready = 0 stalls by one cycle with no word lost or repeated.
- fifo_empty toggling while busy is ignored.

## Configuration
- MSG_DISASM_HEADER_EN defined: SM_HDR is present and HEADER_WORD precedes every packet (WORDS_PER_PACKET+1 words on the wire).
- MSG_DISASM_HEADER_EN not defined: SM_HDR and HEADER_WORD are unused; the packet goes out raw (WORDS_PER_PACKET words).

## Test plan
- Reset, FIFO empty, 20 cycles: fifo_rd_en = 0, data_out_valid = 0, busy = 0 throughout.
- One packet 32'hDEADBEEF, ready = 1, no macro: pop at cycle t; data_out = EF, BE, AD, DE at cycles t+2 through t+5; busy drops at t+6.
- Same packet with MSG_DISASM_HEADER_EN: A5, EF, BE, AD, DE on consecutive cycles starting at t+2.
- Back-pressure: ready pattern 1,0,0,1,0,1,1,… : exactly 4 words delivered in order, with data_out stable during each stall.
- Three packets queued back-to-back (11223344, 55667788, 99AABBCC), ready = 1: 12 words in order; 3 pops, each 6 cycles apart.
- n_reset pulsed low after the 2nd word of packet 11223344, second packet 55667788 still queued: outputs clear the next cycle; after release the next pop yields 88, 77, 66, 55 and no 33 or 11 reappears.
